// File: rtl/cgra_kernel_launcher_pkg.sv
// Shared types and defaults for the CGRA kernel launcher.
// The optional Done synchronizer is selected by CGRA_LAUNCH_DONE_SYNC_EN.
package cgra_kernel_launcher_pkg;

    localparam int CNT_WIDTH_DEF  = 32;
    localparam int LCNT_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_RELEASE = 2'd2
    } launch_state_e;

endpackage

// File: rtl/cgra_kernel_launcher_if.sv
// Host/CGRA handshake bundle for the kernel launcher.
// The master modport is the launcher; the slave modport is the host and the CGRA together.
interface cgra_kernel_launcher_if
    import cgra_kernel_launcher_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int LCNT_WIDTH = LCNT_WIDTH_DEF
);
    logic                  Launch_Req;
    logic                  Launch_Ack;
    logic [CNT_WIDTH-1:0]  Timeout_Limit;
    logic                  Clear_Status;
    logic                  Computation_Start;
    logic                  Computation_Done;
    logic                  Busy;
    logic                  Done_Sticky;
    logic                  Timeout_Err;
    logic                  Kernel_Irq;
    logic [CNT_WIDTH-1:0]  Cycle_Count;
    logic [LCNT_WIDTH-1:0] Launch_Count;

    modport master (
        input  Launch_Req, Timeout_Limit, Clear_Status, Computation_Done,
        output Launch_Ack, Computation_Start, Busy, Done_Sticky, Timeout_Err,
               Kernel_Irq, Cycle_Count, Launch_Count
    );

    modport slave (
        output Launch_Req, Timeout_Limit, Clear_Status, Computation_Done,
        input  Launch_Ack, Computation_Start, Busy, Done_Sticky, Timeout_Err,
               Kernel_Irq, Cycle_Count, Launch_Count
    );

endinterface

// File: rtl/cgra_launch_sync.sv
// Two-flop reset-to-0 synchronizer for Computation_Done.
// Instantiated only when CGRA_LAUNCH_DONE_SYNC_EN is defined.
module cgra_launch_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic ff1_q, ff2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/cgra_kernel_launcher.sv
// Host-side initiator of the four-phase CGRA Start/Done handshake with timeout,
// sticky status and completion IRQ. Define CGRA_LAUNCH_DONE_SYNC_EN to synchronize Done.
module cgra_kernel_launcher
    import cgra_kernel_launcher_pkg::*;
#(
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter int LCNT_WIDTH = LCNT_WIDTH_DEF
) (
    input logic                  Clk,
    input logic                  Resetn,
    cgra_kernel_launcher_if.master bus
);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LCNT_WIDTH-1:0] LCNT_ONE = {{(LCNT_WIDTH-1){1'b0}}, 1'b1};

    launch_state_e         state_q, state_d;
    logic                  start_q, start_d;
    logic                  busy_q, busy_d;
    logic                  abort_q, abort_d;
    logic                  sticky_q, sticky_d;
    logic                  terr_q, terr_d;
    logic                  irq_q, irq_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LCNT_WIDTH-1:0] lcnt_q, lcnt_d;
    logic                  ack_c;
    logic                  set_done, set_to;
    logic                  done_s;

`ifdef CGRA_LAUNCH_DONE_SYNC_EN
    cgra_launch_sync u_done_sync (
        .clk_i  (Clk),
        .rst_ni (Resetn),
        .d_i    (bus.Computation_Done),
        .q_o    (done_s)
    );
`else
    assign done_s = bus.Computation_Done;
`endif

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        abort_d  = abort_q;
        cnt_d    = cnt_q;
        lcnt_d   = lcnt_q;
        irq_d    = 1'b0;
        ack_c    = 1'b0;
        set_done = 1'b0;
        set_to   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A stale Done blocks acceptance; the request simply stays pending.
                if (Resetn && bus.Launch_Req && !done_s) begin
                    ack_c   = 1'b1;
                    state_d = ST_START;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
                // Done is tested first so it wins a same-cycle race with the timeout.
                if (done_s) begin
                    state_d = ST_RELEASE;
                    start_d = 1'b0;
                end else if (bus.Timeout_Limit != '0 &&
                             cnt_q == bus.Timeout_Limit - CNT_ONE) begin
                    state_d = ST_RELEASE;
                    start_d = 1'b0;
                    abort_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!done_s) begin
                    state_d  = ST_IDLE;
                    irq_d    = 1'b1;
                    lcnt_d   = lcnt_q + LCNT_ONE;
                    set_done = !abort_q;
                    set_to   = abort_q;
                    abort_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
            end
        endcase

        // A set in the same cycle as Clear_Status takes priority.
        sticky_d = set_done ? 1'b1 : (bus.Clear_Status ? 1'b0 : sticky_q);
        terr_d   = set_to   ? 1'b1 : (bus.Clear_Status ? 1'b0 : terr_q);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            abort_q  <= 1'b0;
            sticky_q <= 1'b0;
            terr_q   <= 1'b0;
            irq_q    <= 1'b0;
            cnt_q    <= '0;
            lcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            abort_q  <= abort_d;
            sticky_q <= sticky_d;
            terr_q   <= terr_d;
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
            lcnt_q   <= lcnt_d;
        end
    end

    // Ack is the only Mealy output so acceptance lands in the request cycle.
    assign bus.Launch_Ack        = ack_c;
    assign bus.Computation_Start = start_q;
    assign bus.Busy              = busy_q;
    assign bus.Done_Sticky       = sticky_q;
    assign bus.Timeout_Err       = terr_q;
    assign bus.Kernel_Irq        = irq_q;
    assign bus.Cycle_Count       = cnt_q;
    assign bus.Launch_Count      = lcnt_q;

endmodule

// File: tb/tb_cgra_kernel_launcher.sv
// Scoreboard bench for cgra_kernel_launcher: directed launches push expected
// Ack cycles and completion records; a negedge monitor pops and compares.
module tb_cgra_kernel_launcher;

`ifdef CGRA_LAUNCH_DONE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    typedef struct {
        int          irq_cyc;
        logic [31:0] cc;
        logic        sticky;
        logic        terr;
        logic [15:0] lc;
    } exp_t;

    logic Clk = 1'b0;
    logic Resetn = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] lc_model = '0;

    int   ack_q[$];
    exp_t irq_q[$];

    cgra_kernel_launcher_if #(.CNT_WIDTH(32), .LCNT_WIDTH(16)) bus ();

    cgra_kernel_launcher #(.CNT_WIDTH(32), .LCNT_WIDTH(16)) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (Resetn) begin
            if (bus.Launch_Ack) begin
                if (ack_q.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
                else check("ack_cycle", cyc, ack_q.pop_front());
            end
            if (bus.Kernel_Irq) begin
                if (irq_q.size() == 0) check("irq_unexpected", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = irq_q.pop_front();
                    check("irq_cycle", cyc, e.irq_cyc);
                    check("cycle_count", bus.Cycle_Count, e.cc);
                    check("done_sticky", {31'd0, bus.Done_Sticky}, {31'd0, e.sticky});
                    check("timeout_err", {31'd0, bus.Timeout_Err}, {31'd0, e.terr});
                    check("launch_count", {16'd0, bus.Launch_Count}, {16'd0, e.lc});
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, {31'd0, bus.Computation_Start}, 32'd0);
        check({tag, "_busy"},  {31'd0, bus.Busy}, 32'd0);
        check({tag, "_ack"},   {31'd0, bus.Launch_Ack}, 32'd0);
        check({tag, "_stky"},  {31'd0, bus.Done_Sticky}, 32'd0);
        check({tag, "_terr"},  {31'd0, bus.Timeout_Err}, 32'd0);
        check({tag, "_irq"},   {31'd0, bus.Kernel_Irq}, 32'd0);
        check({tag, "_cc"},    bus.Cycle_Count, 32'd0);
        check({tag, "_lc"},    {16'd0, bus.Launch_Count}, 32'd0);
    endtask

    // One launch, driven cycle by cycle from offsets relative to its start cycle.
    task automatic run(input int limit, input int req_lo, input int ack_k, input int start_hi,
                       input int rise, input int fall, input int breq_lo, input int breq_hi,
                       input int clr_k, input int irq_k, input int total,
                       input logic [31:0] cc, input logic sticky, input logic terr);
        int   t0;
        exp_t e;
        t0 = cyc;
        lc_model++;
        ack_q.push_back(t0 + ack_k);
        e.irq_cyc = t0 + irq_k;
        e.cc      = cc;
        e.sticky  = sticky;
        e.terr    = terr;
        e.lc      = lc_model;
        irq_q.push_back(e);
        bus.Timeout_Limit = limit;
        for (int k = 0; k < total; k++) begin
            bus.Launch_Req       = (k >= req_lo && k <= ack_k) || (k >= breq_lo && k <= breq_hi);
            bus.Computation_Done = (k >= rise && k < fall);
            bus.Clear_Status     = (k == clr_k);
            @(negedge Clk);
            check("start", {31'd0, bus.Computation_Start},
                  {31'd0, (k > ack_k && k <= ack_k + start_hi)});
            tick();
        end
        bus.Launch_Req       = 1'b0;
        bus.Computation_Done = 1'b0;
        bus.Clear_Status     = 1'b0;
    endtask

    initial begin
        bus.Launch_Req       = 1'b0;
        bus.Computation_Done = 1'b0;
        bus.Clear_Status     = 1'b0;
        bus.Timeout_Limit    = '0;
        repeat (3) tick();
        check_all_zero("reset");
        Resetn = 1'b1;
        tick();

        // Normal launch: Done up at 10, down at 14.
        run(0, 0, 0, 10 + L, 10, 14, -1, -1, -1, 15 + L, 18 + L, 10 + L, 1'b1, 1'b0);

        // Clear_Status alone drops both sticky flags.
        bus.Clear_Status = 1'b1;
        tick();
        bus.Clear_Status = 1'b0;
        @(negedge Clk);
        check("clr_sticky", {31'd0, bus.Done_Sticky}, 32'd0);
        check("clr_terr",   {31'd0, bus.Timeout_Err}, 32'd0);
        tick();

        // Timeout of 5 with Done never rising.
        run(5, 0, 0, 5, 1000, 1000, -1, -1, -1, 7, 10, 5, 1'b0, 1'b1);

        // Done seen in the 5th Start cycle beats the timeout; Clear on the set cycle.
        run(5, 0, 0, 5, 5 - L, 9 - L, -1, -1, 9, 10, 13, 5, 1'b1, 1'b0);

        // Stale Done holds off the ack; a request while busy is ignored; ends in timeout.
        run(8, 3, 23 + L, 8, 0, 23, 27, 29, -1, 33 + L, 36 + L, 8, 1'b1, 1'b1);

        // Reset in the 3rd Start cycle.
        bus.Timeout_Limit = '0;
        bus.Launch_Req    = 1'b1;
        ack_q.push_back(cyc);
        tick();
        bus.Launch_Req = 1'b0;
        tick();
        tick();
        check("pre_reset_start", {31'd0, bus.Computation_Start}, 32'd1);
        #1 Resetn = 1'b0;
        #1 check_all_zero("midrst");
        tick();
        Resetn = 1'b1;
        lc_model = '0;
        tick();

        // A fresh launch after the reset behaves normally.
        run(0, 0, 0, 10 + L, 10, 14, -1, -1, -1, 15 + L, 18 + L, 10 + L, 1'b1, 1'b0);

        repeat (3) tick();
        check("ack_q_drained", ack_q.size(), 32'd0);
        check("irq_q_drained", irq_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
